// File: rtl/wdog_window.sv
`default_nettype none
// ============================================================================
//  Module   : wdog_window
//  Purpose  : Windowed system watchdog with prescaler, early-clear window,
//             debug freeze, timed reset pulse, keyed enable/disable with
//             abort-on-wrong-key and unlock timeout, optional enable lock,
//             and a latched cause code.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             debug_mode        - freezes RUN/WARN timing (BITE continues)
//             clear_wdg         - clear strobe, qualified by write_data
//             write_key         - key strobe, qualified by write_data
//             write_data[31:0]  - data for clear/key strobes
//             wd_limit[4:0]     - timeout exponent
//             win_limit[4:0]    - early-clear window exponent (0 = no window)
//             prescale          - tick every prescale+1 clocks
//             nmi               - high while in WARN
//             reset_wdg_n       - low while in BITE
//             enabled           - watchdog armed
//             cause[1:0]        - 00 none, 01 timeout, 10 early clear
//  Revision : 1.0  initial release
// ============================================================================
module wdog_window #(
    parameter int          CNT_WIDTH  = 32,
    parameter int          PRE_WIDTH  = 8,
    parameter int          RST_LIMIT  = 256,
    parameter int          KEY_TO_W   = 24,
    parameter bit          LOCK_ON_EN = 1'b0,
    parameter logic [31:0] CLR_DATA   = 32'hAB_CD_EF_44,
    parameter logic [31:0] EN_DATA_0  = 32'h12_45_67_9A,
    parameter logic [31:0] EN_DATA_1  = 32'h34_BC_76_C5,
    parameter logic [31:0] DS_DATA_0  = 32'h33_DF_E4_74,
    parameter logic [31:0] DS_DATA_1  = 32'h32_79_B5_6E
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 debug_mode,
    input  logic                 clear_wdg,
    input  logic                 write_key,
    input  logic [31:0]          write_data,
    input  logic [4:0]           wd_limit,
    input  logic [4:0]           win_limit,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic                 nmi,
    output logic                 reset_wdg_n,
    output logic                 enabled,
    output logic [1:0]           cause
);

    localparam logic [31:0]          c_max_shift   = 32'(CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_rst_last    = CNT_WIDTH'(RST_LIMIT - 1);
    localparam logic [PRE_WIDTH-1:0] c_pre_one     = PRE_WIDTH'(1);
    localparam logic [KEY_TO_W-1:0]  c_key_one     = KEY_TO_W'(1);
    localparam logic [1:0]           c_cause_tmo   = 2'b01;
    localparam logic [1:0]           c_cause_early = 2'b10;

    typedef enum logic [1:0] {
        KEY_IDLE = 2'd0,
        KEY_EN1  = 2'd1,
        KEY_DS1  = 2'd2
    } key_state_t;

    typedef enum logic [1:0] {
        WD_OFF  = 2'd0,
        WD_RUN  = 2'd1,
        WD_WARN = 2'd2,
        WD_BITE = 2'd3
    } wd_state_t;

    key_state_t           r_key_state, w_key_state_nxt;
    logic [KEY_TO_W-1:0]  r_key_cnt, w_key_cnt_nxt;
    logic                 r_enabled, w_enabled_nxt;

    wd_state_t            r_wd_state, w_wd_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [PRE_WIDTH-1:0] r_pre_cnt, w_pre_cnt_nxt;
    logic [1:0]           r_cause, w_cause_nxt;
    logic                 r_nmi, r_rst_n;

    logic                 w_vc, w_tick;
    logic [31:0]          w_lim_sh, w_win_sh;
    logic [CNT_WIDTH-1:0] w_limit_m1, w_win;

    assign w_vc   = clear_wdg && (write_data == CLR_DATA);
    assign w_tick = (r_pre_cnt == prescale);

    // Exponents are clamped so LIMIT and WIN always fit in the counter.
    always_comb begin
        w_lim_sh = ({27'd0, wd_limit}  > c_max_shift) ? c_max_shift : {27'd0, wd_limit};
        w_win_sh = ({27'd0, win_limit} > c_max_shift) ? c_max_shift : {27'd0, win_limit};
        w_limit_m1 = (c_cnt_one << w_lim_sh) - c_cnt_one;
        w_win      = (win_limit == 5'd0) ? '0 : (c_cnt_one << w_win_sh);
    end

    // ------------------------------------------------------------------
    // Key sequence FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_key_state_nxt = r_key_state;
        w_key_cnt_nxt   = '0;
        w_enabled_nxt   = r_enabled;
        case (r_key_state)
            KEY_IDLE: begin
                if (write_key && write_data == EN_DATA_0) begin
                    w_key_state_nxt = KEY_EN1;
                end else if (write_key && write_data == DS_DATA_0 &&
                             !(LOCK_ON_EN && r_enabled)) begin
                    w_key_state_nxt = KEY_DS1;
                end
            end
            KEY_EN1, KEY_DS1: begin
                // Expiry takes priority: a second key landing on the last
                // count is lost, leaving 2^KEY_TO_W-1 usable cycles.
                if (r_key_cnt == '1) begin
                    w_key_state_nxt = KEY_IDLE;
                end else if (write_key) begin
                    w_key_state_nxt = KEY_IDLE;
                    if (r_key_state == KEY_EN1 && write_data == EN_DATA_1) begin
                        w_enabled_nxt = 1'b1;
                    end
                    if (r_key_state == KEY_DS1 && write_data == DS_DATA_1) begin
                        w_enabled_nxt = 1'b0;
                    end
                end else begin
                    w_key_cnt_nxt = r_key_cnt + c_key_one;
                end
            end
            default: w_key_state_nxt = KEY_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_state <= KEY_IDLE;
            r_key_cnt   <= '0;
            r_enabled   <= 1'b0;
        end else begin
            r_key_state <= w_key_state_nxt;
            r_key_cnt   <= w_key_cnt_nxt;
            r_enabled   <= w_enabled_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_wd_state_nxt = r_wd_state;
        w_cnt_nxt      = r_cnt;
        w_pre_cnt_nxt  = w_tick ? '0 : (r_pre_cnt + c_pre_one);
        w_cause_nxt    = r_cause;
        case (r_wd_state)
            WD_OFF: begin
                w_cnt_nxt     = '0;
                w_pre_cnt_nxt = '0;
                if (r_enabled) begin
                    w_wd_state_nxt = WD_RUN;
                end
            end
            WD_RUN, WD_WARN: begin
                if (!r_enabled) begin
                    w_wd_state_nxt = WD_OFF;
                    w_cnt_nxt      = '0;
                    w_pre_cnt_nxt  = '0;
                end else if (debug_mode) begin
                    w_pre_cnt_nxt = r_pre_cnt;
                end else if (w_vc) begin
                    // A clear beats a coincident terminal tick.
                    w_cnt_nxt     = '0;
                    w_pre_cnt_nxt = '0;
                    if (r_wd_state == WD_WARN) begin
                        w_wd_state_nxt = WD_RUN;
                    end else if (r_cnt < w_win) begin
                        w_wd_state_nxt = WD_WARN;
                        w_cause_nxt    = c_cause_early;
                    end
                end else if (w_tick) begin
                    if (r_cnt == w_limit_m1) begin
                        w_cnt_nxt = '0;
                        if (r_wd_state == WD_RUN) begin
                            w_wd_state_nxt = WD_WARN;
                            w_cause_nxt    = c_cause_tmo;
                        end else begin
                            w_wd_state_nxt = WD_BITE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
            end
            WD_BITE: begin
                // Raw clock cycles; the pulse always runs to completion.
                if (r_cnt == c_rst_last) begin
                    w_cnt_nxt      = '0;
                    w_wd_state_nxt = r_enabled ? WD_RUN : WD_OFF;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_wd_state_nxt = WD_OFF;
                w_cnt_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_state <= WD_OFF;
            r_cnt      <= '0;
            r_pre_cnt  <= '0;
            r_cause    <= 2'b00;
            r_nmi      <= 1'b0;
            r_rst_n    <= 1'b1;
        end else begin
            r_wd_state <= w_wd_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_cause    <= w_cause_nxt;
            // Outputs are registered alongside the state they decode.
            r_nmi      <= (w_wd_state_nxt == WD_WARN);
            r_rst_n    <= (w_wd_state_nxt != WD_BITE);
        end
    end

    assign nmi         = r_nmi;
    assign reset_wdg_n = r_rst_n;
    assign enabled     = r_enabled;
    assign cause       = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_wdog_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wdog_window
//  Purpose  : Scoreboard bench for wdog_window. Each driven cycle advances a
//             behavioural model and queues the outputs expected after the
//             edge; a negedge monitor pops and compares. A second instance
//             with the enable lock shares the stimulus; its enabled output
//             is predicted by the same key model with the lock applied.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wdog_window;

    localparam logic [31:0] K_CLR = 32'hAB_CD_EF_44;
    localparam logic [31:0] K_EN0 = 32'h12_45_67_9A;
    localparam logic [31:0] K_EN1 = 32'h34_BC_76_C5;
    localparam logic [31:0] K_DS0 = 32'h33_DF_E4_74;
    localparam logic [31:0] K_DS1 = 32'h32_79_B5_6E;
    localparam int KEY_W      = 4;
    localparam int KEY_WINDOW = (1 << KEY_W) - 1;
    localparam int RST_LEN    = 256;
    localparam int M_OFF = 0, M_RUN = 1, M_WARN = 2, M_BITE = 3;

    logic        clk;
    logic        reset, debug_mode, clear_wdg, write_key;
    logic [31:0] write_data;
    logic [4:0]  wd_limit, win_limit;
    logic [7:0]  prescale;
    logic        nmi, reset_wdg_n, enabled;
    logic [1:0]  cause;
    logic        nmi_lk, reset_wdg_n_lk, enabled_lk;
    logic [1:0]  cause_lk;

    wdog_window #(.KEY_TO_W(KEY_W), .RST_LIMIT(RST_LEN), .LOCK_ON_EN(1'b0)) dut (
        .clk(clk), .reset(reset), .debug_mode(debug_mode), .clear_wdg(clear_wdg),
        .write_key(write_key), .write_data(write_data), .wd_limit(wd_limit),
        .win_limit(win_limit), .prescale(prescale), .nmi(nmi),
        .reset_wdg_n(reset_wdg_n), .enabled(enabled), .cause(cause)
    );

    wdog_window #(.KEY_TO_W(KEY_W), .RST_LIMIT(RST_LEN), .LOCK_ON_EN(1'b1)) dut_lk (
        .clk(clk), .reset(reset), .debug_mode(debug_mode), .clear_wdg(clear_wdg),
        .write_key(write_key), .write_data(write_data), .wd_limit(wd_limit),
        .win_limit(win_limit), .prescale(prescale), .nmi(nmi_lk),
        .reset_wdg_n(reset_wdg_n_lk), .enabled(enabled_lk), .cause(cause_lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       nmi;
        logic       rstn;
        logic       en;
        logic [1:0] cause;
        logic       en_lk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: watchdog phase, tick count since service, prescaler phase.
    int         m_mode = M_OFF;
    int         m_pre  = 0;
    longint     m_cnt  = 0;
    logic [1:0] m_cause = 2'b00;
    bit         m_armed = 0, lk_armed = 0;
    int         k_phase = 0, k_age = 0, lk_phase = 0, lk_age = 0;
    bit         dbg = 0;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("nmi",         {1'b0, nmi},         {1'b0, e.nmi});
            chk("reset_wdg_n", {1'b0, reset_wdg_n}, {1'b0, e.rstn});
            chk("enabled",     {1'b0, enabled},     {1'b0, e.en});
            chk("cause",       cause,               e.cause);
            chk("enabled_lk",  {1'b0, enabled_lk},  {1'b0, e.en_lk});
        end
    end

    // phase 0: no sequence open; 1: enable pair open; 2: disable pair open.
    task automatic key_model(input bit lock, inout int phase, inout int age,
                             inout bit armed, input bit wk, input logic [31:0] d);
        if (phase == 0) begin
            age = 0;
            if (wk && d == K_EN0) phase = 1;
            else if (wk && d == K_DS0 && !(lock && armed)) phase = 2;
        end else if (age == KEY_WINDOW) begin
            phase = 0;
        end else if (wk) begin
            if (phase == 1 && d == K_EN1) armed = 1;
            if (phase == 2 && d == K_DS1) armed = 0;
            phase = 0;
        end else begin
            age++;
        end
    endtask

    task automatic model_step(input bit r, input bit dg, input bit clr, input bit wk,
                              input logic [31:0] d);
        bit     armed_old, vc, tick;
        longint lim, win;
        int     sh;
        if (r) begin
            m_mode = M_OFF; m_pre = 0; m_cnt = 0; m_cause = 2'b00;
            m_armed = 0; lk_armed = 0; k_phase = 0; k_age = 0; lk_phase = 0; lk_age = 0;
            return;
        end
        armed_old = m_armed;
        key_model(1'b0, k_phase, k_age, m_armed, wk, d);
        key_model(1'b1, lk_phase, lk_age, lk_armed, wk, d);
        sh  = (int'(wd_limit) > 31) ? 31 : int'(wd_limit);
        lim = longint'(1) << sh;
        sh  = (int'(win_limit) > 31) ? 31 : int'(win_limit);
        win = (win_limit == 5'd0) ? 0 : (longint'(1) << sh);
        vc   = clr && (d == K_CLR);
        tick = (m_pre == int'(prescale));
        case (m_mode)
            M_OFF: begin
                m_cnt = 0; m_pre = 0;
                if (armed_old) m_mode = M_RUN;
            end
            M_RUN, M_WARN: begin
                if (!armed_old) begin
                    m_mode = M_OFF; m_cnt = 0; m_pre = 0;
                end else if (dg) begin
                    m_cnt = m_cnt;
                end else if (vc) begin
                    if (m_mode == M_WARN) m_mode = M_RUN;
                    else if (m_cnt < win) begin m_mode = M_WARN; m_cause = 2'b10; end
                    m_cnt = 0; m_pre = 0;
                end else begin
                    m_pre = tick ? 0 : (m_pre + 1) % 256;
                    if (tick) begin
                        if (m_cnt == lim - 1) begin
                            m_cnt = 0;
                            if (m_mode == M_RUN) begin m_mode = M_WARN; m_cause = 2'b01; end
                            else m_mode = M_BITE;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            end
            default: begin
                m_pre = tick ? 0 : (m_pre + 1) % 256;
                if (m_cnt == RST_LEN - 1) begin
                    m_cnt = 0;
                    m_mode = armed_old ? M_RUN : M_OFF;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    task automatic cyc(input bit r, input bit dg, input bit clr, input bit wk,
                       input logic [31:0] d);
        exp_t e;
        reset = r; debug_mode = dg; clear_wdg = clr; write_key = wk; write_data = d;
        model_step(r, dg, clr, wk, d);
        e.nmi = (m_mode == M_WARN);
        e.rstn = (m_mode != M_BITE);
        e.en = m_armed;
        e.cause = m_cause;
        e.en_lk = lk_armed;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, dbg, 1'b0, 1'b0, 32'h0);
    endtask
    task automatic key(input logic [31:0] d);
        cyc(1'b0, dbg, 1'b0, 1'b1, d);
    endtask
    task automatic clr();
        cyc(1'b0, dbg, 1'b1, 1'b0, K_CLR);
    endtask
    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask
    task automatic setup(input int p, input int wd, input int wn);
        prescale = 8'(p); wd_limit = 5'(wd); win_limit = 5'(wn);
    endtask
    task automatic arm();
        key(K_EN0); key(K_EN1);
    endtask

    initial begin
        reset = 1'b1; debug_mode = 1'b0; clear_wdg = 1'b0; write_key = 1'b0;
        write_data = 32'h0; setup(0, 4, 0);
        do_reset();
        idle(3);

        // Timeout escalation to a full bite.
        arm();
        idle(16 + 16 + RST_LEN + 10);

        // Prescaled and serviced, then left to expire.
        do_reset(); setup(3, 3, 0); arm();
        for (int i = 0; i < 10; i++) begin idle(29); clr(); end
        idle(45);

        // Window: sweep the clear position across the early/late boundary.
        for (int k = 0; k < 12; k++) begin
            do_reset(); setup(0, 5, 3); arm(); idle(1 + k); clr(); idle(4); clr(); idle(3);
        end
        // Clear coinciding with the terminal tick.
        for (int k = 0; k < 6; k++) begin
            do_reset(); setup(0, 2, 0); arm(); idle(k); clr(); idle(6);
        end

        // Keys: abort on wrong key, then unlock expiry boundary.
        do_reset(); setup(0, 3, 0);
        key(K_EN0); key(32'hDEAD_BEEF); key(K_EN1); idle(3);
        key(K_EN0); idle(KEY_WINDOW);     key(K_EN1); idle(3);
        key(K_EN0); idle(KEY_WINDOW - 1); key(K_EN1); idle(3);

        // Disable pair during a bite; lock instance stays armed.
        idle(8 + 8);
        key(K_DS0); key(K_DS1);
        idle(RST_LEN + 10);
        arm(); idle(5); key(K_DS0); key(K_DS1); idle(5);

        // Debug freeze mid-count, clears ignored while frozen.
        do_reset(); setup(1, 5, 0); arm(); idle(10);
        dbg = 1; idle(40); clr(); idle(59); dbg = 0;
        idle(80);

        // Reset during a bite.
        do_reset(); setup(0, 2, 0); arm(); idle(4 + 4 + 10);
        do_reset(); idle(3);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          r, c, w;
            logic [31:0] d;
            if (i % 250 == 0) begin
                cyc(1'b0, dbg, 1'b0, 1'b1, K_EN0);
                cyc(1'b0, dbg, 1'b0, 1'b1, K_EN1);
            end
            r = ($urandom_range(0, 399) == 0);
            if (r || i == 0) setup($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) dbg = ~dbg;
            c = ($urandom_range(0, 11) == 0);
            w = !c && ($urandom_range(0, 14) == 0);
            d = $urandom;
            if (c && $urandom_range(0, 3) != 0) d = K_CLR;
            if (w) begin
                case ($urandom_range(0, 4))
                    0: d = K_EN0;
                    1: d = K_EN1;
                    2: d = K_DS0;
                    3: d = K_DS1;
                    default: d = $urandom;
                endcase
            end
            cyc(r, dbg, c, w, d);
        end

        dbg = 0;
        idle(2);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wdog_window.md
# wdog_window

Parametrised windowed watchdog, the next generation of the system watchdog. It adds a clock prescaler, a programmable early-clear window, debug freeze instead of debug clear, a timed reset pulse, abort-on-wrong-key unlock, an optional enable lock, and a latched cause code. It sits on the system control bus next to the reset controller. It drives a warning interrupt (`nmi`) and an active-low watchdog reset request.

## Interface
- `CNT_WIDTH`, 32: width of the timeout counter.
- `PRE_WIDTH`, 8: width of the prescaler.
- `RST_LIMIT`, 256: length in `clk` cycles of the reset pulse; must be at least 1.
- `KEY_TO_W`, 24: width of the unlock timeout counter.
- `LOCK_ON_EN`, 0: when 1, the disable sequence is ignored once the block is enabled.
- `CLR_DATA`, 32'hAB_CD_EF_44: clear key.
- `EN_DATA_0` / `EN_DATA_1`, 32'h12_45_67_9A / 32'h34_BC_76_C5: enable key pair.
- `DS_DATA_0` / `DS_DATA_1`, 32'h33_DF_E4_74 / 32'h32_79_B5_6E: disable key pair.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `debug_mode`  in  1  freezes the timeout logic.
- `clear_wdg`  in  1  clear strobe; valid only when `write_data == CLR_DATA`.
- `write_key`  in  1  key strobe for the enable/disable sequences.
- `write_data`  in  32  data qualifying `clear_wdg` and `write_key`.
- `wd_limit`  in  5  timeout exponent: LIMIT = 1 << min(wd_limit, CNT_WIDTH-1).
- `win_limit`  in  5  window exponent: WIN = 0 if `win_limit` is 0, otherwise 1 << min(win_limit, CNT_WIDTH-1).
- `prescale`  in  PRE_WIDTH  a tick occurs every `prescale`+1 clocks.
- `nmi`  out  1  high while the watchdog FSM is in WARN.
- `reset_wdg_n`  out  1  low while the watchdog FSM is in BITE.
- `enabled`  out  1  watchdog armed.
- `cause`  out  2  cause code: 00 none, 01 timeout, 10 early clear.

## Operation
- Valid clear (VC) = `clear_wdg && write_data == CLR_DATA`.
- **Prescaler**
  - `pre_cnt` counts 0..`prescale`. A tick is generated when `pre_cnt == prescale`, and `pre_cnt` then wraps to 0.
  - `prescale` = 0 gives one tick every cycle.
  - `pre_cnt` is cleared in OFF and on any VC accepted in RUN or WARN.
- **Key FSM** (states IDLE, EN1, DS1)
  - IDLE → EN1 on `write_key` with EN_DATA_0.
  - IDLE → DS1 on `write_key` with DS_DATA_0. If `LOCK_ON_EN` is 1 and `enabled` is 1, this transition is blocked.
  - In EN1: `write_key` with EN_DATA_1 sets `enabled` and returns to IDLE.
  - In DS1: `write_key` with DS_DATA_1 clears `enabled` and returns to IDLE.
  - In EN1 or DS1, a `write_key` with any other value → IDLE (abort).
  - `key_cnt` increments in EN1 and DS1 and is 0 in IDLE. When it is all-ones → IDLE.
- **Watchdog FSM** (states OFF, RUN, WARN, BITE)
  - OFF: `cnt` = 0. Go to RUN when `enabled` is 1.
  - RUN, VC with `cnt >= WIN`: `cnt` ← 0.
  - RUN, VC with `cnt < WIN`: early clear. Go to WARN, `cnt` ← 0, `cause` ← 10.
  - RUN, tick with `cnt == LIMIT-1`: go to WARN, `cnt` ← 0, `cause` ← 01.
  - RUN, other ticks: `cnt` + 1.
  - WARN: VC goes to RUN with `cnt` ← 0; the window is not checked in WARN.
  - WARN: a tick with `cnt == LIMIT-1` goes to BITE with `cnt` ← 0.
  - BITE: `cnt` counts raw `clk` cycles. At `cnt == RST_LIMIT-1` go to RUN with `cnt` ← 0. VC is ignored in BITE.
- **Disable**: `enabled` = 0 forces OFF from RUN or WARN on the next edge. BITE always completes its pulse and then goes to OFF.
- **Debug freeze**: while `debug_mode` is 1 in RUN or WARN, `cnt`, `pre_cnt` and state hold, and VC is ignored. BITE is not frozen.
- **Simultaneous events**
  - VC and a terminal tick in the same cycle: VC wins in RUN (subject to the window) and in WARN.
  - `reset` overrides everything.
- **Counter width**: `cnt` is CNT_WIDTH bits and never wraps, because LIMIT ≤ 2^(CNT_WIDTH-1).
- **`cause`**: holds its value until the next WARN entry or `reset`.

## Timing
- Reset values (all outputs): `nmi` = 0, `reset_wdg_n` = 1, `enabled` = 0, `cause` = 00. All internal state is OFF/IDLE with counters at 0.
- All outputs are registered decodes of state, with no combinational path from inputs.
- Enable: if EN_DATA_1 is written in cycle N, then `enabled` = 1 in N+1 and the FSM is in RUN in N+2.
- Timeout: exactly LIMIT ticks after entering RUN or the last VC, `nmi` rises on the edge following the terminal tick.
- Escalation: `reset_wdg_n` falls LIMIT ticks after `nmi` rises and stays low for exactly RST_LIMIT cycles.
- VC acts on the next edge: `cnt` = 0 in the following cycle, and `nmi` falls at the same edge.
- Key sequence timeout: 2^KEY_TO_W − 1 cycles in EN1 or DS1.

## Test plan
- **Timeout to bite**: enable, `prescale` = 0, `wd_limit` = 4, no clears → `nmi` rises 16 cycles after RUN entry; `reset_wdg_n` is low 16 cycles later for 256 cycles; `cause` = 01.
- **Prescaled, serviced**: `prescale` = 3, `wd_limit` = 3, VC every 30 cycles → `nmi` is never asserted. Stop the clears → `nmi` rises 32 cycles after the last VC.
- **Window**: `win_limit` = 3, `wd_limit` = 5, VC at `cnt` = 5 → WARN next cycle with `cause` = 10. VC at `cnt` = 9 → `cnt` = 0 and the FSM stays in RUN.
- **Keys**: EN_DATA_0, then a wrong key, then EN_DATA_1 → `enabled` stays 0. With `KEY_TO_W` = 4, EN_DATA_0 followed by a 16-cycle gap and then EN_DATA_1 → `enabled` stays 0.
- **Lock and disable**: with `LOCK_ON_EN` = 1, the DS pair leaves `enabled` at 1. With `LOCK_ON_EN` = 0, the DS pair issued during BITE → the full 256-cycle pulse completes, then the FSM goes to OFF.
- **Debug and reset**: `debug_mode` high for 100 cycles mid-count → `cnt` is unchanged afterwards. `reset` asserted during BITE → `reset_wdg_n` = 1 and all outputs are at reset values next cycle.
